// File: rtl/read_reorder_buffer.sv
// In-order read response buffer. Slots are allocated in order, filled out of
// order from the hit and miss ports, and drained in allocation order into a
// single registered AXI R beat.
//
// Handshakes: alloc fires on alloc_valid_i & alloc_ready_o; an R beat
// transfers on rvalid_o & rready_i, and rid_o/rdata_o hold stable while
// rvalid_o is high and rready_i is low. Fill ports have no backpressure.
module read_reorder_buffer #(
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 4,
  parameter int TID_WIDTH    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_valid_i,
  input  logic [ID_WIDTH-1:0]           alloc_id_i,
  output logic                          alloc_ready_o,
  output logic [TID_WIDTH-1:0]          alloc_tid_o,
  input  logic                          rob_wren_i,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_i,
  output logic                          rob_afull_o,
  input  logic                          miss_wren_i,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] miss_data_i,
  output logic [ID_WIDTH-1:0]           rid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rlast_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic                          err_o
);

  localparam int DEPTH = 2 ** TID_WIDTH;
  localparam int CW    = TID_WIDTH + 1;

  logic [DEPTH-1:0]      alloc_q, alloc_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [ID_WIDTH-1:0]   id_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TID_WIDTH-1:0]  head_q, tail_q;
  logic [CW-1:0]         used_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [TID_WIDTH-1:0]  hit_tid, miss_tid;
  logic                  hit_ok, miss_ok, fill_err;
  logic                  alloc_fire, load;
  logic [CW-1:0]         done_cnt;

  assign hit_tid  = rob_data_i[TID_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign miss_tid = miss_data_i[TID_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  // A fill lands only in a slot that is allocated and still waiting; on a
  // same-tid collision the hit port wins and the miss write is an error.
  assign hit_ok   = rob_wren_i & alloc_q[hit_tid] & ~done_q[hit_tid];
  assign miss_ok  = miss_wren_i & alloc_q[miss_tid] & ~done_q[miss_tid] &
                    ~(rob_wren_i & (hit_tid == miss_tid));
  assign fill_err = (rob_wren_i & ~hit_ok) | (miss_wren_i & ~miss_ok);

  assign alloc_ready_o = (used_q != CW'(DEPTH));
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign load          = done_q[head_q] & (~rvalid_q | rready_i);
  assign alloc_tid_o   = tail_q;

  // Number of slots holding data that has not yet moved to the output stage.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      done_cnt = done_cnt + CW'(done_q[i]);
    end
  end

  assign rob_afull_o = (done_cnt >= CW'(DEPTH - AFULL_MARGIN));

  // Next state of the per-slot alloc/done bitmaps.
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (load) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (hit_ok)  done_d[hit_tid]  = 1'b1;
    if (miss_ok) done_d[miss_tid] = 1'b1;
  end

  // Control state, pointers, occupancy, output beat register and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      used_q   <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      used_q  <= used_q + CW'(alloc_fire) - CW'(load);
      if (alloc_fire) tail_q <= tail_q + 1'b1;
      if (load) begin
        head_q   <= head_q + 1'b1;
        rvalid_q <= 1'b1;
        rid_q    <= id_q[head_q];
        rdata_q  <= data_q[head_q];
      end else if (rready_i) begin
        rvalid_q <= 1'b0;
      end
      if (fill_err) err_q <= 1'b1;
    end
  end

  // Slot payload storage; contents are only meaningful while alloc is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) id_q[tail_q] <= alloc_id_i;
    if (hit_ok)     data_q[hit_tid]  <= rob_data_i[DATA_WIDTH-1:0];
    if (miss_ok)    data_q[miss_tid] <= miss_data_i[DATA_WIDTH-1:0];
  end

  assign rvalid_o = rvalid_q;
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = 2'b00;
  assign rlast_o  = 1'b1;
  assign err_o    = err_q;

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Bench for read_reorder_buffer: directed scenarios plus a randomized stream,
// checked every cycle against a queue-based model of the buffer.
module tb_read_reorder_buffer;

  localparam int DW = 512;
  localparam int IW = 4;
  localparam int TW = 4;
  localparam int DEPTH = 16;
  localparam int CMPW = TW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              alloc_valid = 1'b0;
  logic [IW-1:0]     alloc_id = '0;
  logic              alloc_ready_o;
  logic [TW-1:0]     alloc_tid_o;
  logic              rob_wren = 1'b0;
  logic [TW+DW-1:0]  rob_data = '0;
  logic              rob_afull_o;
  logic              miss_wren = 1'b0;
  logic [TW+DW-1:0]  miss_data = '0;
  logic [IW-1:0]     rid_o;
  logic [DW-1:0]     rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              rvalid_o;
  logic              rready = 1'b0;
  logic              err_o;

  read_reorder_buffer #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_id_i(alloc_id),
    .alloc_ready_o(alloc_ready_o), .alloc_tid_o(alloc_tid_o),
    .rob_wren_i(rob_wren), .rob_data_i(rob_data), .rob_afull_o(rob_afull_o),
    .miss_wren_i(miss_wren), .miss_data_i(miss_data),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready), .err_o(err_o)
  );

  // ---------------- reference model ----------------
  int              pend[$];          // allocated tids, oldest first, not yet in output stage
  bit              m_alloc [DEPTH];
  bit              m_done  [DEPTH];
  logic [IW-1:0]   m_id    [DEPTH];
  logic [DW-1:0]   m_data  [DEPTH];
  int              m_tail;
  bit              out_v;
  logic [IW-1:0]   out_id;
  logic [DW-1:0]   out_data;
  bit              m_err;
  logic [IW-1:0]   got_ids[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [CMPW-1:0] obs, input logic [CMPW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int done_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_done[i]);
    return c;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 0;
      m_done[i]  = 0;
    end
    m_tail = 0;
    out_v = 0;
    out_id = '0;
    out_data = '0;
    m_err = 0;
  endtask

  task automatic check_all();
    chk("rvalid", rvalid_o, out_v);
    if (out_v) begin
      chk("rid", rid_o, out_id);
      chk("rdata", rdata_o, out_data);
    end
    chk("alloc_ready", alloc_ready_o, pend.size() != DEPTH);
    chk("alloc_tid", alloc_tid_o, m_tail[TW-1:0]);
    chk("afull", rob_afull_o, done_count() >= DEPTH - 2);
    chk("err", err_o, m_err);
    chk("rresp", rresp_o, 2'b00);
    chk("rlast", rlast_o, 1'b1);
  endtask

  // One clock: decide on the settled pre-edge inputs, advance the model, check.
  task automatic tick();
    bit a_fire, hok, mok, dr, m_bad, h_bad;
    int ht, mt;
    @(negedge clk);
    if (rvalid_o && rready) got_ids.push_back(rid_o);
    a_fire = alloc_valid && (pend.size() != DEPTH);
    ht  = int'(rob_data[TW+DW-1:DW]);
    mt  = int'(miss_data[TW+DW-1:DW]);
    hok = rob_wren && m_alloc[ht] && !m_done[ht];
    mok = miss_wren && m_alloc[mt] && !m_done[mt] && !(rob_wren && ht == mt);
    h_bad = rob_wren && !hok;
    m_bad = miss_wren && !mok;
    dr  = (pend.size() > 0) && m_done[pend[0]] && (!out_v || rready);
    @(posedge clk);
    #1;
    if (dr) begin
      out_v = 1;
      out_id = m_id[pend[0]];
      out_data = m_data[pend[0]];
      m_alloc[pend[0]] = 0;
      m_done[pend[0]] = 0;
      void'(pend.pop_front());
    end else if (rready) begin
      out_v = 0;
    end
    if (a_fire) begin
      m_alloc[m_tail] = 1;
      m_done[m_tail] = 0;
      m_id[m_tail] = alloc_id;
      pend.push_back(m_tail);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (hok) begin
      m_data[ht] = rob_data[DW-1:0];
      m_done[ht] = 1;
    end
    if (mok) begin
      m_data[mt] = miss_data[DW-1:0];
      m_done[mt] = 1;
    end
    if (h_bad || m_bad) m_err = 1;
    check_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    alloc_valid = 0;
    rob_wren = 0;
    miss_wren = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    chk("rst_rid", rid_o, '0);
    chk("rst_rdata", rdata_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic alloc_one(input logic [IW-1:0] id);
    idle();
    alloc_valid = 1;
    alloc_id = id;
    tick();
    alloc_valid = 0;
  endtask

  task automatic hit_fill(input int tid, input logic [DW-1:0] d);
    idle();
    rob_wren = 1;
    rob_data = {tid[TW-1:0], d};
    tick();
    rob_wren = 0;
  endtask

  task automatic idle_ticks(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d0;
    int cand[$];
    model_reset();
    #1;
    do_reset();

    // 1: three allocs filled out of order drain in allocation order
    rready = 1;
    for (int k = 1; k <= 3; k++) begin
      chk("t1_tid", alloc_tid_o, k - 1);
      alloc_one(k[IW-1:0]);
    end
    got_ids.delete();
    hit_fill(2, rnd_data());
    hit_fill(0, rnd_data());
    hit_fill(1, rnd_data());
    idle_ticks(5);
    chk("t1_nbeats", got_ids.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_ids.size()) chk("t1_order", got_ids[k], k + 1);
    end

    // 2: fill to full, afull, then drain
    do_reset();
    rready = 0;
    for (int k = 0; k < DEPTH; k++) alloc_one($urandom_range(0, 15));
    chk("t2_full", alloc_ready_o, 1'b0);
    alloc_valid = 1;
    tick();
    idle();
    for (int k = 0; k < DEPTH; k++) hit_fill(k, rnd_data());
    chk("t2_afull", rob_afull_o, 1'b1);
    rready = 1;
    idle_ticks(DEPTH + 4);
    chk("t2_afull_clr", rob_afull_o, 1'b0);
    chk("t2_ready", alloc_ready_o, 1'b1);

    // 3: simultaneous fills, distinct then identical tids
    do_reset();
    rready = 1;
    alloc_one(4'h5);
    alloc_one(4'h6);
    idle();
    rob_wren = 1;  rob_data  = {4'd0, rnd_data()};
    miss_wren = 1; miss_data = {4'd1, rnd_data()};
    tick();
    idle_ticks(4);
    chk("t3_noerr", err_o, 1'b0);
    alloc_one(4'h7);
    idle();
    rob_wren = 1;  rob_data  = {4'd2, rnd_data()};
    miss_wren = 1; miss_data = {4'd2, rnd_data()};
    tick();
    idle_ticks(4);
    chk("t3_err", err_o, 1'b1);

    // 4 + 5: stray fills, refill of a done slot, R backpressure hold
    do_reset();
    rready = 0;
    alloc_one(4'h9);
    hit_fill(5, rnd_data());
    chk("t4_err", err_o, 1'b1);
    chk("t4_nobeat", rvalid_o, 1'b0);
    d0 = rnd_data();
    hit_fill(0, d0);
    hit_fill(0, rnd_data());
    idle_ticks(5);
    chk("t5_hold_valid", rvalid_o, 1'b1);
    chk("t5_hold_data", rdata_o, d0);
    alloc_one(4'hA);
    hit_fill(1, rnd_data());
    idle_ticks(2);
    rready = 1;
    idle_ticks(3);
    chk("t4_sticky", err_o, 1'b1);

    // 6: randomized stream with wrap and a mid-stream reset
    do_reset();
    for (int c = 0; c < 80; c++) begin
      if (c == 40) do_reset();
      idle();
      rready = ($urandom_range(0, 3) != 0);
      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_id = IW'($urandom_range(0, 15));
      cand.delete();
      foreach (pend[i]) if (!m_done[pend[i]]) cand.push_back(pend[i]);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        rob_wren = 1;
        rob_data = {cand[$urandom_range(0, cand.size() - 1)][TW-1:0], rnd_data()};
      end
      if (cand.size() > 1 && $urandom_range(0, 3) == 0) begin
        miss_wren = 1;
        miss_data = {cand[$urandom_range(0, cand.size() - 1)][TW-1:0], rnd_data()};
      end
      if ($urandom_range(0, 15) == 0) begin
        miss_wren = 1;
        miss_data = {TW'($urandom_range(0, 15)), rnd_data()};
      end
      tick();
    end
    // flush whatever is still outstanding
    rready = 1;
    for (int c = 0; c < 3 * DEPTH && pend.size() > 0; c++) begin
      idle();
      cand.delete();
      foreach (pend[i]) if (!m_done[pend[i]]) cand.push_back(pend[i]);
      if (cand.size() > 0) begin
        rob_wren = 1;
        rob_data = {cand[0][TW-1:0], rnd_data()};
      end
      tick();
    end
    idle_ticks(3);
    chk("t6_drained", rvalid_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
